// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock with a registered borrow.
// Optional signed-overflow output is built when SERIAL_SUB_OVF_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; operands captured on an accepted start
// SHIFT | one bit of a - b per cycle, WIDTH cycles
// DONE  | result registered, done pulses for one cycle
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] sa, sb, sd;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             x, y, d, br_nx;
    logic [WIDTH-1:0] sd_nx;

`ifdef SERIAL_SUB_OVF_EN
    logic am, bm;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (cnt == LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Half-subtractor pair; sd_nx already holds the final aligned result on the last bit.
    always_comb begin
        x     = sa[0];
        y     = sb[0];
        d     = x ^ y ^ br;
        br_nx = (~x & y) | (~(x ^ y) & br);
        sd_nx = {d, sd[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == SHIFT);
            done  <= (state_nx == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            sd     <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            am     <= 1'b0;
            bm     <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        sd  <= '0;
                        br  <= 1'b0;
                        cnt <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        am  <= a[WIDTH-1];
                        bm  <= b[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sd  <= sd_nx;
                    br  <= br_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff   <= sd_nx;
                        borrow <= br_nx;
`ifdef SERIAL_SUB_OVF_EN
                        ovf    <= (am != bm) && (d != am);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Directed and random checks of serial_sub at WIDTH 2, 8 and 32.
// Overflow checks are compiled in when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub;

    logic clk;
    logic rst_n;

    logic        st2, st8, st32;
    logic [1:0]  a2, b2, diff2;
    logic [7:0]  a8, b8, diff8;
    logic [31:0] a32, b32, diff32;
    logic        busy2, busy8, busy32;
    logic        done2, done8, done32;
    logic        borrow2, borrow8, borrow32;
`ifdef SERIAL_SUB_OVF_EN
    logic        ovf2, ovf8, ovf32;
`endif

    int total = 0;
    int bad = 0;
    logic [31:0] held[3];

    serial_sub #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf8)
`endif
    );

    serial_sub #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .diff(diff2), .borrow(borrow2)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf2)
`endif
    );

    serial_sub #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(st32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .diff(diff32), .borrow(borrow32)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf32)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic int wi(input int w);
        case (w)
            2:       return 0;
            8:       return 1;
            default: return 2;
        endcase
    endfunction

    function automatic logic [31:0] get_diff(input int w);
        case (w)
            2:       return {30'd0, diff2};
            8:       return {24'd0, diff8};
            default: return diff32;
        endcase
    endfunction

    function automatic logic get_done(input int w);
        case (w)
            2:       return done2;
            8:       return done8;
            default: return done32;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            2:       return busy2;
            8:       return busy8;
            default: return busy32;
        endcase
    endfunction

    function automatic logic get_borrow(input int w);
        case (w)
            2:       return borrow2;
            8:       return borrow8;
            default: return borrow32;
        endcase
    endfunction

`ifdef SERIAL_SUB_OVF_EN
    function automatic logic get_ovf(input int w);
        case (w)
            2:       return ovf2;
            8:       return ovf8;
            default: return ovf32;
        endcase
    endfunction
`endif

    task automatic drive(input int w, input logic s, input logic [31:0] av, input logic [31:0] bv);
        case (w)
            2:       begin st2 = s;  a2 = av[1:0];  b2 = bv[1:0];  end
            8:       begin st8 = s;  a8 = av[7:0];  b8 = bv[7:0];  end
            default: begin st32 = s; a32 = av;      b32 = bv;      end
        endcase
    endtask

    // Called at the mid-cycle point of the start cycle T; returns in cycle T+w+2 (IDLE).
    task automatic do_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] ed, input logic eb, input logic eo, input string nm);
        int   lat;
        logic busy_ok, held_ok;
        drive(w, 1'b1, av, bv);
        @(negedge clk);
        drive(w, 1'b0, $urandom, $urandom);
        lat = 1;
        busy_ok = 1'b1;
        held_ok = 1'b1;
        while (get_done(w) !== 1'b1 && lat <= w + 4) begin
            if (get_busy(w) !== 1'b1) busy_ok = 1'b0;
            if (get_diff(w) !== held[wi(w)]) held_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, lat, w + 1);
        chk({nm, " busy"}, {31'd0, busy_ok & (get_busy(w) === 1'b0)}, 32'd1);
        chk({nm, " held"}, {31'd0, held_ok}, 32'd1);
        chk({nm, " diff"}, get_diff(w), ed);
        chk({nm, " borrow"}, {31'd0, get_borrow(w)}, {31'd0, eb});
`ifdef SERIAL_SUB_OVF_EN
        chk({nm, " ovf"}, {31'd0, get_ovf(w)}, {31'd0, eo});
`endif
        held[wi(w)] = ed;
        @(negedge clk);
        chk({nm, " done pulse"}, {31'd0, get_done(w)}, 32'd0);
    endtask

    task automatic rand_op(input int w);
        logic [31:0] mask, av, bv, d;
        logic        eo;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        av = $urandom & mask;
        bv = $urandom & mask;
        d  = (av - bv) & mask;
        eo = (av[w-1] != bv[w-1]) && (d[w-1] != av[w-1]);
        do_op(w, av, bv, d, av < bv, eo, $sformatf("rand w%0d", w));
    endtask

    initial begin
        int pat_bad;
        logic exp_done, exp_busy;

        tbl[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        tbl[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        tbl[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        tbl[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        tbl[4] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        tbl[5] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        tbl[6] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
        tbl[7] = '{8'hAA, 8'h55, 8'h55, 1'b0, 1'b1};
        tbl[8] = '{8'h10, 8'h01, 8'h0F, 1'b0, 1'b0};

        rst_n = 1'b0;
        drive(2, 1'b0, 0, 0);
        drive(8, 1'b0, 0, 0);
        drive(32, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) held[i] = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", {31'd0, busy8}, 32'd0);
        chk("reset done", {31'd0, done8}, 32'd0);
        chk("reset diff", {24'd0, diff8}, 32'd0);
        chk("reset borrow", {31'd0, borrow8}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("reset ovf", {31'd0, ovf8}, 32'd0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            do_op(8, {24'd0, tbl[i].a}, {24'd0, tbl[i].b}, {24'd0, tbl[i].d},
                  tbl[i].bo, tbl[i].ov, $sformatf("vec%0d", i));

        // start pulses at T+4 (SHIFT) and T+9 (DONE) are ignored; T+10 is accepted
        pat_bad = 0;
        drive(8, 1'b1, 32'h10, 32'h01);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            exp_done = (c == 9) || (c == 19);
            exp_busy = (c >= 1 && c <= 8) || (c >= 11 && c <= 18);
            if (done8 !== exp_done || busy8 !== exp_busy) pat_bad++;
            if (c == 9) chk("busy_start first diff", {24'd0, diff8}, 32'h0F);
            if (c == 19) begin
                chk("busy_start second diff", {24'd0, diff8}, 32'h55);
                chk("busy_start second borrow", {31'd0, borrow8}, 32'd0);
            end
            drive(8, (c == 4) || (c == 9) || (c == 10), 32'hAA, 32'h55);
        end
        drive(8, 1'b0, 0, 0);
        chk("busy_start done/busy pattern", pat_bad, 0);
        held[1] = 32'h55;

        // reset asserted in cycle T+3 of an operation
        drive(8, 1'b1, 32'hF0, 32'h0F);
        @(negedge clk);
        drive(8, 1'b0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort busy", {31'd0, busy8}, 32'd0);
        chk("abort diff", {24'd0, diff8}, 32'd0);
        chk("abort borrow", {31'd0, borrow8}, 32'd0);
        pat_bad = 0;
        for (int c = 0; c < 12; c++) begin
            if (done8 !== 1'b0 || busy8 !== 1'b0) pat_bad++;
            @(negedge clk);
        end
        chk("abort no done", pat_bad, 0);
        for (int i = 0; i < 3; i++) held[i] = '0;
        do_op(8, 32'h05, 32'h03, 32'h02, 1'b0, 1'b0, "after abort");

        for (int i = 0; i < 300; i++) rand_op(8);
        for (int i = 0; i < 150; i++) rand_op(2);
        for (int i = 0; i < 100; i++) rand_op(32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
